// File: rtl/hsv_core_axil_arbiter.sv
// hsv_core_axil_arbiter: shares one AXI-Lite port between dmem (s0) and imem (s1),
// with independent round-robin read and write paths locked to one owner while busy.
module hsv_core_axil_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk_core,
  input  logic            rst_core,
  input  logic [AW-1:0]   i_s0_awaddr,
  input  logic [2:0]      i_s0_awprot,
  input  logic            i_s0_awvalid,
  output logic            o_s0_awready,
  input  logic [DW-1:0]   i_s0_wdata,
  input  logic [DW/8-1:0] i_s0_wstrb,
  input  logic            i_s0_wvalid,
  output logic            o_s0_wready,
  output logic [1:0]      o_s0_bresp,
  output logic            o_s0_bvalid,
  input  logic            i_s0_bready,
  input  logic [AW-1:0]   i_s0_araddr,
  input  logic [2:0]      i_s0_arprot,
  input  logic            i_s0_arvalid,
  output logic            o_s0_arready,
  output logic [DW-1:0]   o_s0_rdata,
  output logic [1:0]      o_s0_rresp,
  output logic            o_s0_rvalid,
  input  logic            i_s0_rready,
  input  logic [AW-1:0]   i_s1_awaddr,
  input  logic [2:0]      i_s1_awprot,
  input  logic            i_s1_awvalid,
  output logic            o_s1_awready,
  input  logic [DW-1:0]   i_s1_wdata,
  input  logic [DW/8-1:0] i_s1_wstrb,
  input  logic            i_s1_wvalid,
  output logic            o_s1_wready,
  output logic [1:0]      o_s1_bresp,
  output logic            o_s1_bvalid,
  input  logic            i_s1_bready,
  input  logic [AW-1:0]   i_s1_araddr,
  input  logic [2:0]      i_s1_arprot,
  input  logic            i_s1_arvalid,
  output logic            o_s1_arready,
  output logic [DW-1:0]   o_s1_rdata,
  output logic [1:0]      o_s1_rresp,
  output logic            o_s1_rvalid,
  input  logic            i_s1_rready,
  output logic [AW-1:0]   o_m_awaddr,
  output logic [2:0]      o_m_awprot,
  output logic            o_m_awvalid,
  input  logic            i_m_awready,
  output logic [DW-1:0]   o_m_wdata,
  output logic [DW/8-1:0] o_m_wstrb,
  output logic            o_m_wvalid,
  input  logic            i_m_wready,
  input  logic [1:0]      i_m_bresp,
  input  logic            i_m_bvalid,
  output logic            o_m_bready,
  output logic [AW-1:0]   o_m_araddr,
  output logic [2:0]      o_m_arprot,
  output logic            o_m_arvalid,
  input  logic            i_m_arready,
  input  logic [DW-1:0]   i_m_rdata,
  input  logic [1:0]      i_m_rresp,
  input  logic            i_m_rvalid,
  output logic            o_m_rready
);
  typedef enum logic {R_IDLE, R_BUSY} rstate_t;
  typedef enum logic {W_IDLE, W_BUSY} wstate_t;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
  rstate_t r_rstate, w_rstate_n;
  wstate_t r_wstate, w_wstate_n;
  logic r_rowner, r_rprio, r_wowner, r_wprio;
  logic w_rowner_n, w_rprio_n, w_wowner_n, w_wprio_n;
  logic [CNT_WIDTH-1:0] r_rd_out, r_aw_out, r_w_out, w_rd_out_n, w_aw_out_n, w_w_out_n;
  logic w_rbusy, w_rcand, w_rsel, w_ar_en, w_ar_hs, w_r_hs;
  logic w_wbusy, w_wcand, w_wsel, w_aw_en, w_w_en, w_aw_hs, w_w_hs, w_b_hs;
  // A response retiring this cycle frees its slot, so a new request may issue alongside it.
  assign w_rbusy     = r_rstate == R_BUSY;
  assign w_rcand     = (i_s0_arvalid & i_s1_arvalid) ? r_rprio : i_s1_arvalid;
  assign w_rsel      = w_rbusy ? r_rowner : w_rcand;
  assign o_m_rready  = w_rbusy & (r_rowner ? i_s1_rready : i_s0_rready);
  assign w_r_hs      = i_m_rvalid & o_m_rready;
  assign w_ar_en     = !w_rbusy | (r_rd_out < MAX_CNT) | w_r_hs;
  assign o_m_arvalid = w_ar_en & (w_rsel ? i_s1_arvalid : i_s0_arvalid);
  assign o_m_araddr  = w_rsel ? i_s1_araddr : i_s0_araddr;
  assign o_m_arprot  = w_rsel ? i_s1_arprot : i_s0_arprot;
  assign w_ar_hs     = o_m_arvalid & i_m_arready;
  assign o_s0_arready = w_ar_hs & !w_rsel;
  assign o_s1_arready = w_ar_hs & w_rsel;
  assign o_s0_rvalid = w_rbusy & !r_rowner & i_m_rvalid;
  assign o_s1_rvalid = w_rbusy & r_rowner & i_m_rvalid;
  assign o_s0_rdata  = i_m_rdata;
  assign o_s1_rdata  = i_m_rdata;
  assign o_s0_rresp  = i_m_rresp;
  assign o_s1_rresp  = i_m_rresp;
  assign w_wbusy     = r_wstate == W_BUSY;
  assign w_wcand     = ((i_s0_awvalid | i_s0_wvalid) & (i_s1_awvalid | i_s1_wvalid)) ? r_wprio : (i_s1_awvalid | i_s1_wvalid);
  assign w_wsel      = w_wbusy ? r_wowner : w_wcand;
  assign o_m_bready  = w_wbusy & (r_wowner ? i_s1_bready : i_s0_bready);
  assign w_b_hs      = i_m_bvalid & o_m_bready;
  assign w_aw_en     = !w_wbusy | (r_aw_out < MAX_CNT) | w_b_hs;
  assign w_w_en      = !w_wbusy | (r_w_out < MAX_CNT) | w_b_hs;
  assign o_m_awvalid = w_aw_en & (w_wsel ? i_s1_awvalid : i_s0_awvalid);
  assign o_m_awaddr  = w_wsel ? i_s1_awaddr : i_s0_awaddr;
  assign o_m_awprot  = w_wsel ? i_s1_awprot : i_s0_awprot;
  assign o_m_wvalid  = w_w_en & (w_wsel ? i_s1_wvalid : i_s0_wvalid);
  assign o_m_wdata   = w_wsel ? i_s1_wdata : i_s0_wdata;
  assign o_m_wstrb   = w_wsel ? i_s1_wstrb : i_s0_wstrb;
  assign w_aw_hs     = o_m_awvalid & i_m_awready;
  assign w_w_hs      = o_m_wvalid & i_m_wready;
  assign o_s0_awready = w_aw_hs & !w_wsel;
  assign o_s1_awready = w_aw_hs & w_wsel;
  assign o_s0_wready = w_w_hs & !w_wsel;
  assign o_s1_wready = w_w_hs & w_wsel;
  assign o_s0_bvalid = w_wbusy & !r_wowner & i_m_bvalid;
  assign o_s1_bvalid = w_wbusy & r_wowner & i_m_bvalid;
  assign o_s0_bresp  = i_m_bresp;
  assign o_s1_bresp  = i_m_bresp;
  always_comb begin
    w_rstate_n = r_rstate;
    w_rowner_n = r_rowner;
    w_rprio_n  = r_rprio;
    w_rd_out_n = r_rd_out + CNT_WIDTH'(w_ar_hs) - CNT_WIDTH'(w_r_hs);
    if (!w_rbusy && w_ar_hs) begin
      w_rstate_n = R_BUSY;
      w_rowner_n = w_rcand;
    end else if (w_rbusy && w_rd_out_n == '0) begin
      w_rstate_n = R_IDLE;
      w_rprio_n  = ~r_rowner;
    end
  end
  always_comb begin
    w_wstate_n = r_wstate;
    w_wowner_n = r_wowner;
    w_wprio_n  = r_wprio;
    w_aw_out_n = r_aw_out + CNT_WIDTH'(w_aw_hs) - CNT_WIDTH'(w_b_hs);
    w_w_out_n  = r_w_out + CNT_WIDTH'(w_w_hs) - CNT_WIDTH'(w_b_hs);
    if (!w_wbusy && (w_aw_hs || w_w_hs)) begin
      w_wstate_n = W_BUSY;
      w_wowner_n = w_wcand;
    end else if (w_wbusy && w_aw_out_n == '0 && w_w_out_n == '0) begin
      w_wstate_n = W_IDLE;
      w_wprio_n  = ~r_wowner;
    end
  end
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
      r_rowner <= 1'b0;
      r_rprio  <= 1'b0;
      r_wowner <= 1'b0;
      r_wprio  <= 1'b0;
      r_rd_out <= '0;
      r_aw_out <= '0;
      r_w_out  <= '0;
    end else begin
      r_rstate <= w_rstate_n;
      r_wstate <= w_wstate_n;
      r_rowner <= w_rowner_n;
      r_rprio  <= w_rprio_n;
      r_wowner <= w_wowner_n;
      r_wprio  <= w_wprio_n;
      r_rd_out <= w_rd_out_n;
      r_aw_out <= w_aw_out_n;
      r_w_out  <= w_w_out_n;
    end
  end
endmodule

// File: tb/tb_hsv_core_axil_arbiter.sv
// tb_hsv_core_axil_arbiter: directed checks of read/write arbitration, throttling and reset.
module tb_hsv_core_axil_arbiter;
  logic clk_core = 1'b0, rst_core = 1'b0;
  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata, s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0] s0_awprot, s0_arprot, s1_awprot, s1_arprot, m_awprot, m_arprot;
  logic [3:0] s0_wstrb, s1_wstrb, m_wstrb;
  logic [1:0] s0_bresp, s0_rresp, s1_bresp, s1_rresp, m_bresp, m_rresp;
  logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  int n_tests = 0, n_fail = 0;
  always #5 clk_core = ~clk_core;
  hsv_core_axil_arbiter dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .i_s0_awaddr(s0_awaddr), .i_s0_awprot(s0_awprot), .i_s0_awvalid(s0_awvalid), .o_s0_awready(s0_awready),
    .i_s0_wdata(s0_wdata), .i_s0_wstrb(s0_wstrb), .i_s0_wvalid(s0_wvalid), .o_s0_wready(s0_wready),
    .o_s0_bresp(s0_bresp), .o_s0_bvalid(s0_bvalid), .i_s0_bready(s0_bready),
    .i_s0_araddr(s0_araddr), .i_s0_arprot(s0_arprot), .i_s0_arvalid(s0_arvalid), .o_s0_arready(s0_arready),
    .o_s0_rdata(s0_rdata), .o_s0_rresp(s0_rresp), .o_s0_rvalid(s0_rvalid), .i_s0_rready(s0_rready),
    .i_s1_awaddr(s1_awaddr), .i_s1_awprot(s1_awprot), .i_s1_awvalid(s1_awvalid), .o_s1_awready(s1_awready),
    .i_s1_wdata(s1_wdata), .i_s1_wstrb(s1_wstrb), .i_s1_wvalid(s1_wvalid), .o_s1_wready(s1_wready),
    .o_s1_bresp(s1_bresp), .o_s1_bvalid(s1_bvalid), .i_s1_bready(s1_bready),
    .i_s1_araddr(s1_araddr), .i_s1_arprot(s1_arprot), .i_s1_arvalid(s1_arvalid), .o_s1_arready(s1_arready),
    .o_s1_rdata(s1_rdata), .o_s1_rresp(s1_rresp), .o_s1_rvalid(s1_rvalid), .i_s1_rready(s1_rready),
    .o_m_awaddr(m_awaddr), .o_m_awprot(m_awprot), .o_m_awvalid(m_awvalid), .i_m_awready(m_awready),
    .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb), .o_m_wvalid(m_wvalid), .i_m_wready(m_wready),
    .i_m_bresp(m_bresp), .i_m_bvalid(m_bvalid), .o_m_bready(m_bready),
    .o_m_araddr(m_araddr), .o_m_arprot(m_arprot), .o_m_arvalid(m_arvalid), .i_m_arready(m_arready),
    .i_m_rdata(m_rdata), .i_m_rresp(m_rresp), .i_m_rvalid(m_rvalid), .o_m_rready(m_rready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask
  task automatic idle_inputs();
    {s0_awvalid, s0_wvalid, s0_bready, s0_arvalid, s0_rready} = '0;
    {s1_awvalid, s1_wvalid, s1_bready, s1_arvalid, s1_rready} = '0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    {s0_awaddr, s0_wdata, s0_araddr, s1_awaddr, s1_wdata, s1_araddr, m_rdata} = '0;
    {s0_awprot, s0_arprot, s1_awprot, s1_arprot} = '0;
    s0_wstrb = 4'hf;
    s1_wstrb = 4'hf;
    m_bresp = 2'b00;
    m_rresp = 2'b00;
  endtask
  task automatic do_reset();
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, {29'd0, s0_arready | s1_arready, s0_awready | s1_awready, s0_wready | s1_wready}, 32'd0);
    chk({tag, "_mvalid"}, {29'd0, m_arvalid, m_awvalid, m_wvalid}, 32'd0);
    chk({tag, "_mready"}, {30'd0, m_rready, m_bready}, 32'd0);
  endtask
  initial begin
    idle_inputs();
    do_reset();
    #1;
    chk("rst_rstate", 32'(dut.r_rstate), 32'd0);
    chk("rst_rd_out", 32'(dut.r_rd_out), 32'd0);
    chk("rst_rprio", 32'(dut.r_rprio), 32'd0);
    chk("rst_wprio", 32'(dut.r_wprio), 32'd0);
    chk_quiet("rst");
    // s0 alone: three back-to-back reads, each answered one cycle later
    m_arready = 1'b1;
    s0_rready = 1'b1;
    s0_arvalid = 1'b1;
    s0_araddr = 32'h100;
    #1;
    chk("t1_m_araddr0", m_araddr, 32'h100);
    chk("t1_arready0", s0_arready, 1'b1);
    tick();
    for (int i = 1; i < 4; i++) begin
      s0_arvalid = i < 3;
      s0_araddr = 32'h100 + 32'(4 * i);
      m_rvalid = 1'b1;
      m_rdata = 32'hA0 + 32'(i - 1);
      #1;
      chk("t1_ar_nobubble", m_arvalid, 32'(i < 3));
      chk("t1_s0_rvalid", s0_rvalid, 1'b1);
      chk("t1_s0_rdata", s0_rdata, 32'hA0 + 32'(i - 1));
      chk("t1_s1_rvalid", s1_rvalid, 1'b0);
      tick();
      chk("t1_rd_out", 32'(dut.r_rd_out), 32'(i < 3));
    end
    m_rvalid = 1'b0;
    chk("t1_idle", 32'(dut.r_rstate), 32'd0);
    chk("t1_rprio", 32'(dut.r_rprio), 32'd1);
    // simultaneous requests after reset: s0 wins, s1 waits for s0 to drain
    idle_inputs();
    do_reset();
    m_arready = 1'b1;
    s0_arvalid = 1'b1;
    s0_araddr = 32'h200;
    s1_arvalid = 1'b1;
    s1_araddr = 32'h300;
    #1;
    chk("t2_m_araddr", m_araddr, 32'h200);
    chk("t2_s0_arready", s0_arready, 1'b1);
    chk("t2_s1_arready", s1_arready, 1'b0);
    tick();
    s0_arvalid = 1'b0;
    #1;
    chk("t2_s1_blocked", s1_arready, 1'b0);
    chk("t2_m_arvalid", m_arvalid, 1'b0);
    tick();
    m_rvalid = 1'b1;
    m_rdata = 32'hB0;
    s0_rready = 1'b1;
    #1;
    chk("t2_s0_rvalid", s0_rvalid, 1'b1);
    chk("t2_s1_rvalid", s1_rvalid, 1'b0);
    chk("t2_s1_still_blocked", s1_arready, 1'b0);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("t2_s1_m_araddr", m_araddr, 32'h300);
    chk("t2_s1_granted", s1_arready, 1'b1);
    tick();
    chk("t2_owner", 32'(dut.r_rowner), 32'd1);
    s1_arvalid = 1'b0;
    s1_rready = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hB1;
    #1;
    chk("t2_s1_rvalid", s1_rvalid, 1'b1);
    chk("t2_s1_rdata", s1_rdata, 32'hB1);
    chk("t2_s0_rvalid_off", s0_rvalid, 1'b0);
    tick();
    m_rvalid = 1'b0;
    chk("t2_rprio", 32'(dut.r_rprio), 32'd0);
    // s1 five reads with R withheld: four accepted, fifth rides the first response
    m_arready = 1'b1;
    s1_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s1_araddr = 32'h400 + 32'(4 * i);
      #1;
      chk("t3_accept", s1_arready, 1'b1);
      tick();
    end
    chk("t3_rd_out_full", 32'(dut.r_rd_out), 32'd4);
    s1_araddr = 32'h410;
    #1;
    chk("t3_throttle_rdy", s1_arready, 1'b0);
    chk("t3_throttle_mv", m_arvalid, 1'b0);
    tick();
    m_rvalid = 1'b1;
    #1;
    chk("t3_same_cycle", s1_arready, 1'b1);
    chk("t3_m_araddr", m_araddr, 32'h410);
    tick();
    chk("t3_rd_out_hold", 32'(dut.r_rd_out), 32'd4);
    s1_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    m_rvalid = 1'b0;
    chk("t3_idle", 32'(dut.r_rstate), 32'd0);
    chk("t3_rd_out_zero", 32'(dut.r_rd_out), 32'd0);
    // s0 write with W two cycles ahead of AW
    idle_inputs();
    m_awready = 1'b1;
    m_wready = 1'b1;
    s0_bready = 1'b1;
    s0_wvalid = 1'b1;
    s0_wdata = 32'hDEAD;
    #1;
    chk("t4_m_wdata", m_wdata, 32'hDEAD);
    chk("t4_wready", s0_wready, 1'b1);
    chk("t4_no_aw", m_awvalid, 1'b0);
    tick();
    chk("t4_granted", 32'(dut.r_wstate), 32'd1);
    s0_wvalid = 1'b0;
    tick();
    s0_awvalid = 1'b1;
    s0_awaddr = 32'h500;
    #1;
    chk("t4_awready", s0_awready, 1'b1);
    chk("t4_m_awaddr", m_awaddr, 32'h500);
    tick();
    chk("t4_counts", {28'd0, 2'(dut.r_aw_out), 2'(dut.r_w_out)}, 32'h5);
    s0_awvalid = 1'b0;
    m_bvalid = 1'b1;
    m_bresp = 2'b10;
    #1;
    chk("t4_s0_bvalid", s0_bvalid, 1'b1);
    chk("t4_s0_bresp", s0_bresp, 2'b10);
    chk("t4_s1_bvalid", s1_bvalid, 1'b0);
    tick();
    m_bvalid = 1'b0;
    chk("t4_release", 32'(dut.r_wstate), 32'd0);
    chk("t4_wprio", 32'(dut.r_wprio), 32'd1);
    // s0 holds reads while s1 writes in parallel
    m_arready = 1'b1;
    s0_arvalid = 1'b1;
    s0_rready = 1'b1;
    tick();
    tick();
    chk("t5_rd_out", 32'(dut.r_rd_out), 32'd2);
    s0_arvalid = 1'b0;
    s1_awvalid = 1'b1;
    s1_wvalid = 1'b1;
    s1_awaddr = 32'h600;
    s1_wdata = 32'h1234;
    s1_bready = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hC0;
    #1;
    chk("t5_aw", {30'd0, s1_awready, s1_wready}, 32'd3);
    chk("t5_m_awaddr", m_awaddr, 32'h600);
    chk("t5_m_wdata", m_wdata, 32'h1234);
    chk("t5_s0_rdata", s0_rvalid ? s0_rdata : 32'hx, 32'hC0);
    tick();
    s1_awvalid = 1'b0;
    s1_wvalid = 1'b0;
    m_rvalid = 1'b0;
    m_bvalid = 1'b1;
    #1;
    chk("t5_s1_bvalid", s1_bvalid, 1'b1);
    chk("t5_s0_bvalid", s0_bvalid, 1'b0);
    chk("t5_rd_unaffected", {28'd0, 1'(dut.r_rowner), 3'(dut.r_rd_out)}, 32'd1);
    tick();
    m_bvalid = 1'b0;
    chk("t5_wprio", 32'(dut.r_wprio), 32'd0);
    // reset with three reads in flight
    s0_arvalid = 1'b1;
    tick();
    tick();
    s0_arvalid = 1'b0;
    chk("t6_rd_out_pre", 32'(dut.r_rd_out), 32'd3);
    idle_inputs();
    do_reset();
    m_rvalid = 1'b1;
    #1;
    chk("t6_rstate", 32'(dut.r_rstate), 32'd0);
    chk("t6_rd_out", 32'(dut.r_rd_out), 32'd0);
    chk("t6_rprio", 32'(dut.r_rprio), 32'd0);
    chk("t6_no_rvalid", {30'd0, s0_rvalid, s1_rvalid}, 32'd0);
    chk_quiet("t6");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
